softmax_den_seq: RTL and testbench

- Sequential controller that collects one softmax vector of N block-floating-point exponentials (5-bit exponent, 16-bit mantissa) through a valid/ready stream.
- Buffers the elements while tracking the maximum exponent, then runs one element per cycle through a shared align-and-accumulate datapath.
- Emits the denominator in the 37-bit {exponent, 20-bit sum, 12'b0} format used by the divide stage.
- Sits between the exp-approximation stage and the softmax divider, replacing the 5-input combinational denominator when N varies or area matters.

---
 rtl/softmax_den_seq.sv | 138 +++++++++++++
 tb/tb_softmax_den_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_den_seq.sv
`default_nettype none
// ============================================================================
// Module   : softmax_den_seq
// Brief    : Sequential softmax denominator; buffers N BFP exponentials,
//            aligns them to the maximum exponent and accumulates one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module softmax_den_seq #(
  parameter int N  = 5,
  parameter int EW = 5,
  parameter int MW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EW+MW-1:0]     in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EW+20+12-1:0]  out_den,
  output logic                 busy
);

  localparam int AW = 20;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SUM  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [EW-1:0]        max_q, max_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [EW+MW-1:0]     elem_q [N];
  logic                 elem_we;

  logic [EW-1:0]        w_sh;
  logic [MW-1:0]        w_mant;
  logic [AW-1:0]        w_addend;
  logic [EW-1:0]        w_in_e;

  assign w_in_e = in_exp[EW+MW-1:MW];
  assign w_sh   = max_q - elem_q[idx_q][EW+MW-1:MW];
  assign w_mant = elem_q[idx_q][MW-1:0];

  // Shifts of MW or more flush the term entirely.
  always_comb begin
    w_addend = '0;
    if (32'(w_sh) < 32'(MW)) begin
      w_addend = {{(AW-MW){1'b0}}, w_mant >> w_sh};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    acc_d   = acc_q;
    elem_we = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          elem_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          max_d   = (w_in_e > max_q) ? w_in_e : max_q;
          if (cnt_q == C_LAST) begin
            state_d = S_SUM;
            cnt_d   = '0;
            idx_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_SUM: begin
        acc_d = acc_q + w_addend;
        idx_d = idx_q + 1'b1;
        if (idx_q == C_LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          max_d   = '0;
          acc_d   = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Abort wins over everything, including a same-cycle input handshake.
    if (clear) begin
      state_d = S_LOAD;
      cnt_d   = '0;
      idx_d   = '0;
      max_d   = '0;
      acc_d   = '0;
      elem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (elem_we) begin
      elem_q[cnt_q] <= in_exp;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_LOAD);
  assign out_den   = out_valid ? {max_q, acc_q, 12'b0} : '0;

endmodule
`default_nettype wire

// File: tb/tb_softmax_den_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_softmax_den_seq
// Brief    : Scoreboard bench for softmax_den_seq (N=5 and N=16 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_den_seq;

  localparam int NA = 5;
  localparam int NB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n, clear, in_valid, out_ready;
  logic [20:0] in_exp;
  logic        in_ready, out_valid, busy;
  logic [36:0] out_den;

  logic        b_clear, b_in_valid, b_out_ready;
  logic [20:0] b_in_exp;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [36:0] b_out_den;

  softmax_den_seq #(.N(NA), .EW(5), .MW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_den(out_den),
    .busy(busy)
  );

  softmax_den_seq #(.N(NB), .EW(5), .MW(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_exp(b_in_exp),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_den(b_out_den),
    .busy(b_busy)
  );

  typedef struct {
    logic [36:0] den;
    int          acc_cyc;
  } exp_t;

  exp_t sbq_a[$];
  exp_t sbq_b[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor, N=5 instance: compare on the rising out_valid, then hold checks.
  logic        a_prev_v = 1'b0;
  logic [36:0] a_held   = '0;
  always @(negedge clk) begin
    if (out_valid && !a_prev_v) begin
      if (sbq_a.size() == 0) begin
        check("a_unexpected_out", 64'(out_den), 64'hDEAD);
      end else begin
        exp_t e;
        e = sbq_a.pop_front();
        check("a_den", 64'(out_den), 64'(e.den));
        check("a_latency", 64'(cyc - e.acc_cyc), 64'(NA));
      end
      a_held <= out_den;
    end else if (out_valid && a_prev_v) begin
      check("a_den_stable", 64'(out_den), 64'(a_held));
    end
    a_prev_v <= out_valid;
  end

  logic b_prev_v = 1'b0;
  always @(negedge clk) begin
    if (b_out_valid && !b_prev_v) begin
      if (sbq_b.size() == 0) begin
        check("b_unexpected_out", 64'(b_out_den), 64'hDEAD);
      end else begin
        exp_t e;
        e = sbq_b.pop_front();
        check("b_den", 64'(b_out_den), 64'(e.den));
        check("b_latency", 64'(cyc - e.acc_cyc), 64'(NB));
      end
    end
    b_prev_v <= b_out_valid;
  end

  logic [20:0] vec [16];

  function automatic logic [20:0] mk(input logic [4:0] e, input logic [15:0] m);
    return {e, m};
  endfunction

  // Entered and left at posedge+1; returns the cyc value after the accepting edge.
  task automatic send(input logic [20:0] e, input int gap, output int acc_cyc);
    bit done;
    int w;
    acc_cyc = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_exp   = e;
    done     = 1'b0;
    w        = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc = cyc + 1;
        done    = 1'b1;
      end else if (w > 200) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        done = 1'b1;
      end
      w++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int n, input int maxgap, input logic [36:0] expd, input bit push);
    int ac;
    ac = 0;
    for (int i = 0; i < n; i++) begin
      send(vec[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, ac);
    end
    if (push) sbq_a.push_back('{den: expd, acc_cyc: ac});
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sbq_a.size() != 0 || out_valid) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_timeout", 64'(sbq_a.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic set_mixed();
    vec[0] = mk(5'd2, 16'hFFFF);
    vec[1] = mk(5'd4, 16'h8000);
    vec[2] = mk(5'd1, 16'h4000);
    vec[3] = mk(5'd4, 16'h1000);
    vec[4] = mk(5'd3, 16'h2000);
  endtask

  task automatic set_all(input logic [20:0] e);
    for (int i = 0; i < 16; i++) vec[i] = e;
  endtask

  initial begin
    int w;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_exp = '0; out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_exp = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_den", 64'(out_den), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal exponents
    set_all(mk(5'd3, 16'h8000));
    send_vec(5, 0, 37'h3_2800_0000, 1'b1);
    wait_drain();

    // Mixed exponents, back to back then with random gaps
    set_mixed();
    send_vec(5, 0, 37'h4_0E7F_F000, 1'b1);
    wait_drain();
    send_vec(5, 3, 37'h4_0E7F_F000, 1'b1);
    wait_drain();

    // Shift beyond mantissa width
    vec[0] = mk(5'd31, 16'h0001);
    vec[1] = mk(5'd0, 16'hFFFF);
    vec[2] = '0; vec[3] = '0; vec[4] = '0;
    send_vec(5, 0, 37'h1F_0000_1000, 1'b1);
    wait_drain();

    // Backpressure in DONE, then a smaller-exponent vector
    out_ready = 1'b0;
    set_mixed();
    send_vec(5, 0, 37'h4_0E7F_F000, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    check("bp_out_valid_after", 64'(out_valid), 64'd0);
    set_all(mk(5'd1, 16'h1000));
    send_vec(5, 0, 37'h1_0500_0000, 1'b1);
    wait_drain();

    // Clear after 3 accepts; the handshake coinciding with clear is dropped
    set_all(mk(5'd20, 16'hFFFF));
    send_vec(3, 0, '0, 1'b0);
    in_valid = 1'b1;
    in_exp   = mk(5'd20, 16'hFFFF);
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_in_ready", 64'(in_ready), 64'd1);
    set_all(mk(5'd3, 16'h8000));
    send_vec(5, 1, 37'h3_2800_0000, 1'b1);
    wait_drain();

    // Asynchronous reset in the middle of SUM
    send_vec(5, 0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_den", 64'(out_den), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec[0] = mk(5'd31, 16'h0001);
    vec[1] = mk(5'd0, 16'hFFFF);
    vec[2] = '0; vec[3] = '0; vec[4] = '0;
    send_vec(5, 0, 37'h1F_0000_1000, 1'b1);
    wait_drain();

    // Maximum sum on the N=16 instance
    b_in_exp   = mk(5'd7, 16'hFFFF);
    b_in_valid = 1'b1;
    repeat (NB) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    sbq_b.push_back('{den: 37'h7_FFFF_0000, acc_cyc: cyc});
    w = 0;
    while ((sbq_b.size() != 0 || b_out_valid) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("b_drain", 64'(sbq_b.size()), 64'd0);

    check("a_queue_empty", 64'(sbq_a.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
